// File: rtl/neopixel_decoder_if.sv
// Decoded-pixel output bundle of the NeoPixel decoder.
// The decoder drives it through the master modport; consumers use the slave modport.
interface neopixel_decoder_if;
  logic        pixel_valid;
  logic [23:0] pixel_data;
  logic [7:0]  pixel_index;
  logic        frame_done;
  logic [7:0]  frame_pixels;
  logic        err_glitch;
  logic        err_partial;
  logic        err_overflow;

  modport master (
    output pixel_valid, pixel_data, pixel_index,
    output frame_done, frame_pixels,
    output err_glitch, err_partial, err_overflow
  );

  modport slave (
    input pixel_valid, pixel_data, pixel_index,
    input frame_done, frame_pixels,
    input err_glitch, err_partial, err_overflow
  );
endinterface

// File: rtl/neopixel_decoder.sv
// WS2812 single-wire receiver: recovers 24-bit {R,G,B} pixels, frame ends and line errors.
// state         | meaning
// ST_WAIT_LATCH | ignore the line until a latch-length low is seen
// ST_IDLE       | line low after a latch, waiting for the first high of a frame
// ST_HIGH       | measuring a high pulse
// ST_LOW        | measuring the low gap after a bit
module neopixel_decoder #(
  parameter int C_PIXELS            = 12,
  parameter int C_BIT_THRESH_CYCLES = 75,
  parameter int C_MIN_HIGH_CYCLES   = 12,
  parameter int C_MAX_HIGH_CYCLES   = 250,
  parameter int C_LATCH_CYCLES      = 6250
) (
  input  logic                      neopixel_clock,
  input  logic                      neopixel_reset,
  input  logic                      neopixel_din,
  neopixel_decoder_if.master        px
);

  localparam logic [15:0] THRESH_C = 16'(C_BIT_THRESH_CYCLES);
  localparam logic [15:0] MIN_HI_C = 16'(C_MIN_HIGH_CYCLES);
  localparam logic [15:0] MAX_HI_C = 16'(C_MAX_HIGH_CYCLES);
  localparam logic [15:0] LATCH_C  = 16'(C_LATCH_CYCLES);
  localparam logic [7:0]  PIX_MAX  = 8'(C_PIXELS);

  typedef enum logic [1:0] {
    ST_WAIT_LATCH = 2'd0,
    ST_IDLE       = 2'd1,
    ST_HIGH       = 2'd2,
    ST_LOW        = 2'd3
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic [15:0] hi_cnt_q, hi_cnt_d;
  logic [15:0] lo_cnt_q, lo_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  pix_cnt_q, pix_cnt_d;
  logic [23:0] shift_q, shift_d;

  logic        pixel_valid_q, pixel_valid_d;
  logic [23:0] pixel_data_q, pixel_data_d;
  logic [7:0]  pixel_index_q, pixel_index_d;
  logic        frame_done_q, frame_done_d;
  logic [7:0]  frame_pixels_q, frame_pixels_d;
  logic        err_glitch_q, err_glitch_d;
  logic        err_partial_q, err_partial_d;
  logic        err_overflow_q, err_overflow_d;

  logic        din_s;
  logic [15:0] hi_inc;
  logic [15:0] lo_inc;
  logic        ev_bit;
  logic        ev_eof;
  logic        ev_glitch;
  logic [23:0] word;

  assign din_s  = sync_q[1];
  assign hi_inc = sat_inc(hi_cnt_q);
  assign lo_inc = sat_inc(lo_cnt_q);
  assign word   = {shift_q[22:0], (hi_cnt_q >= THRESH_C)};

  always_ff @(posedge neopixel_clock or negedge neopixel_reset) begin
    if (!neopixel_reset) begin
      state_q        <= ST_WAIT_LATCH;
      sync_q         <= 2'b00;
      hi_cnt_q       <= 16'd0;
      lo_cnt_q       <= 16'd0;
      bit_cnt_q      <= 5'd0;
      pix_cnt_q      <= 8'd0;
      shift_q        <= 24'd0;
      pixel_valid_q  <= 1'b0;
      pixel_data_q   <= 24'd0;
      pixel_index_q  <= 8'd0;
      frame_done_q   <= 1'b0;
      frame_pixels_q <= 8'd0;
      err_glitch_q   <= 1'b0;
      err_partial_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      hi_cnt_q       <= hi_cnt_d;
      lo_cnt_q       <= lo_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      pix_cnt_q      <= pix_cnt_d;
      shift_q        <= shift_d;
      pixel_valid_q  <= pixel_valid_d;
      pixel_data_q   <= pixel_data_d;
      pixel_index_q  <= pixel_index_d;
      frame_done_q   <= frame_done_d;
      frame_pixels_q <= frame_pixels_d;
      err_glitch_q   <= err_glitch_d;
      err_partial_q  <= err_partial_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  always_comb begin : p_next_state
    state_d   = state_q;
    ev_bit    = 1'b0;
    ev_eof    = 1'b0;
    ev_glitch = 1'b0;
    case (state_q)
      ST_WAIT_LATCH: begin
        if (!din_s && (lo_inc >= LATCH_C)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (din_s) state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (din_s) begin
          // A line stuck high means the driver has stopped sending.
          if (hi_inc >= MAX_HI_C) begin
            ev_eof  = 1'b1;
            state_d = ST_WAIT_LATCH;
          end
        end else if (hi_cnt_q < MIN_HI_C) begin
          ev_glitch = 1'b1;
          state_d   = ST_WAIT_LATCH;
        end else begin
          ev_bit  = 1'b1;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (din_s) begin
          state_d = ST_HIGH;
        end else if (lo_inc >= LATCH_C) begin
          ev_eof  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_WAIT_LATCH;
    endcase
  end

  always_comb begin : p_outputs
    sync_d         = {sync_q[0], neopixel_din};
    hi_cnt_d       = hi_cnt_q;
    lo_cnt_d       = lo_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    pix_cnt_d      = pix_cnt_q;
    shift_d        = shift_q;
    pixel_valid_d  = 1'b0;
    pixel_data_d   = pixel_data_q;
    pixel_index_d  = pixel_index_q;
    frame_done_d   = 1'b0;
    frame_pixels_d = frame_pixels_q;
    err_glitch_d   = 1'b0;
    err_partial_d  = 1'b0;
    err_overflow_d = 1'b0;

    case (state_q)
      ST_WAIT_LATCH: begin
        lo_cnt_d = din_s ? 16'd0 : lo_inc;
      end
      ST_IDLE: begin
        if (din_s) hi_cnt_d = 16'd1;
      end
      ST_HIGH: begin
        if (din_s) hi_cnt_d = hi_inc;
      end
      ST_LOW: begin
        if (din_s) hi_cnt_d = 16'd1;
        else       lo_cnt_d = lo_inc;
      end
      default: ;
    endcase

    if (ev_glitch) begin
      err_glitch_d = 1'b1;
      bit_cnt_d    = 5'd0;
      pix_cnt_d    = 8'd0;
      lo_cnt_d     = 16'd1;
    end

    if (ev_bit) begin
      shift_d  = word;
      lo_cnt_d = 16'd1;
      if (bit_cnt_q == 5'd23) begin
        bit_cnt_d = 5'd0;
        if (pix_cnt_q == PIX_MAX) begin
          err_overflow_d = 1'b1;
        end else begin
          // Wire order is G,R,B; present as {R,G,B}.
          pixel_valid_d = 1'b1;
          pixel_data_d  = {word[15:8], word[23:16], word[7:0]};
          pixel_index_d = pix_cnt_q;
          pix_cnt_d     = pix_cnt_q + 8'd1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end

    if (ev_eof) begin
      err_partial_d = (bit_cnt_q != 5'd0);
      if (pix_cnt_q != 8'd0) begin
        frame_done_d   = 1'b1;
        frame_pixels_d = pix_cnt_q;
      end
      pix_cnt_d = 8'd0;
      bit_cnt_d = 5'd0;
      lo_cnt_d  = 16'd0;
    end
  end

  assign px.pixel_valid  = pixel_valid_q;
  assign px.pixel_data   = pixel_data_q;
  assign px.pixel_index  = pixel_index_q;
  assign px.frame_done   = frame_done_q;
  assign px.frame_pixels = frame_pixels_q;
  assign px.err_glitch   = err_glitch_q;
  assign px.err_partial  = err_partial_q;
  assign px.err_overflow = err_overflow_q;

endmodule

// File: tb/tb_neopixel_decoder.sv
// Directed bench for neopixel_decoder: pulses are logged on the falling clock edge,
// and the stimulus sequence checks the logs against hand-computed values.
module tb_neopixel_decoder;

  logic clk = 1'b0;
  logic rst_n;
  logic din;

  always #5 clk = ~clk;

  neopixel_decoder_if px ();

  neopixel_decoder dut (
    .neopixel_clock (clk),
    .neopixel_reset (rst_n),
    .neopixel_din   (din),
    .px             (px)
  );

  int n_vec = 0;
  int n_err = 0;

  int          pv_n = 0;
  int          fd_n = 0;
  int          gl_n = 0;
  int          pa_n = 0;
  int          ov_n = 0;
  logic [7:0]  fp_last = 8'd0;
  logic [23:0] pd_log [0:63];
  logic [7:0]  pi_log [0:63];

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (px.pixel_valid === 1'b1) begin
        if (pv_n < 64) begin
          pd_log[pv_n] = px.pixel_data;
          pi_log[pv_n] = px.pixel_index;
        end
        pv_n = pv_n + 1;
      end
      if (px.frame_done === 1'b1) begin
        fd_n    = fd_n + 1;
        fp_last = px.frame_pixels;
      end
      if (px.err_glitch === 1'b1)   gl_n = gl_n + 1;
      if (px.err_partial === 1'b1)  pa_n = pa_n + 1;
      if (px.err_overflow === 1'b1) ov_n = ov_n + 1;
    end
  end

  int hi1 = 80;
  int lo1 = 12;
  int hi0 = 20;
  int lo0 = 12;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (b) begin drive(1'b1, hi1); drive(1'b0, lo1); end
    else   begin drive(1'b1, hi0); drive(1'b0, lo0); end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_pixel(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
    send_byte(g);
    send_byte(r);
    send_byte(b);
  endtask

  int pv0, fd0, gl0, pa0, ov0;

  task automatic snap();
    pv0 = pv_n; fd0 = fd_n; gl0 = gl_n; pa0 = pa_n; ov0 = ov_n;
  endtask

  logic [31:0] outs_all;

  initial begin
    din   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    outs_all = {px.pixel_valid, px.frame_done, px.err_glitch, px.err_partial, px.err_overflow};
    chk("reset_pulses", outs_all, 32'd0);
    chk("reset_data", {8'd0, px.pixel_data}, 32'd0);
    chk("reset_index_fp", {16'd0, px.pixel_index, px.frame_pixels}, 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 6300);

    // Single pixel with nominal WS2812 timing.
    hi1 = 100; lo1 = 55; hi0 = 50; lo0 = 108;
    snap();
    send_pixel(8'h00, 8'h80, 8'hFF);
    drive(1'b0, 6300);
    chk("p1_valid_cnt", pv_n - pv0, 1);
    chk("p1_data", {8'd0, pd_log[pv0]}, 32'h008000FF);
    chk("p1_index", {24'd0, pi_log[pv0]}, 0);
    chk("p1_frame_done", fd_n - fd0, 1);
    chk("p1_frame_pixels", {24'd0, fp_last}, 1);
    chk("p1_errors", (gl_n - gl0) + (pa_n - pa0) + (ov_n - ov0), 0);

    // 13 pixels into a 12-pixel frame, ended by a stuck-high line.
    hi1 = 80; lo1 = 12; hi0 = 20; lo0 = 12;
    snap();
    for (int p = 0; p < 13; p++) send_pixel(8'hA5, 8'hA5, 8'hA5);
    drive(1'b1, 300);
    chk("ovf_valid_cnt", pv_n - pv0, 12);
    for (int p = 0; p < 12; p++) begin
      chk("ovf_index", {24'd0, pi_log[pv0 + p]}, p);
      chk("ovf_data", {8'd0, pd_log[pv0 + p]}, 32'h00A5A5A5);
    end
    chk("ovf_err_overflow", ov_n - ov0, 1);
    chk("ovf_frame_done", fd_n - fd0, 1);
    chk("ovf_frame_pixels", {24'd0, fp_last}, 12);
    chk("ovf_partial", pa_n - pa0, 0);
    chk("ovf_hold_data", {8'd0, px.pixel_data}, 32'h00A5A5A5);
    chk("ovf_hold_index", {24'd0, px.pixel_index}, 11);

    // Without a full latch-length low the next frame is ignored.
    snap();
    drive(1'b0, 3000);
    send_pixel(8'h01, 8'h02, 8'h03);
    drive(1'b0, 6300);
    chk("nolatch_valid_cnt", pv_n - pv0, 0);
    chk("nolatch_frame_done", fd_n - fd0, 0);

    // Threshold boundary: 74 cycles high is a 0, 75 is a 1.
    snap();
    drive(1'b1, 74); drive(1'b0, 20);
    drive(1'b1, 75); drive(1'b0, 20);
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    send_byte(8'h12);
    send_byte(8'h34);
    drive(1'b1, 75); drive(1'b0, 20);
    drive(1'b1, 74); drive(1'b0, 20);
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    send_byte(8'h00);
    send_byte(8'h00);
    drive(1'b0, 6300);
    chk("thr_valid_cnt", pv_n - pv0, 2);
    chk("thr_data0", {8'd0, pd_log[pv0]}, 32'h00124034);
    chk("thr_index0", {24'd0, pi_log[pv0]}, 0);
    chk("thr_data1", {8'd0, pd_log[pv0 + 1]}, 32'h00008000);
    chk("thr_index1", {24'd0, pi_log[pv0 + 1]}, 1);
    chk("thr_frame_pixels", {24'd0, fp_last}, 2);

    // 11-cycle high mid-pixel, then a pixel that must be ignored.
    snap();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    drive(1'b1, 11); drive(1'b0, 20);
    send_pixel(8'hFF, 8'hFF, 8'hFF);
    drive(1'b0, 6300);
    chk("gl_err_glitch", gl_n - gl0, 1);
    chk("gl_valid_cnt", pv_n - pv0, 0);
    chk("gl_frame_done", fd_n - fd0, 0);
    chk("gl_partial", pa_n - pa0, 0);

    // 10 bits, zeros at exactly the minimum high time, then latch.
    hi0 = 12;
    snap();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    drive(1'b0, 6300);
    hi0 = 20;
    chk("part_err_partial", pa_n - pa0, 1);
    chk("part_glitch", gl_n - gl0, 0);
    chk("part_valid_cnt", pv_n - pv0, 0);
    chk("part_frame_done", fd_n - fd0, 0);

    // Reset during pixel 3.
    snap();
    send_pixel(8'h11, 8'h22, 8'h33);
    send_pixel(8'h44, 8'h55, 8'h66);
    send_byte(8'h77);
    drive(1'b1, 40);
    chk("rst_pre_valid_cnt", pv_n - pv0, 2);
    chk("rst_pre_data0", {8'd0, pd_log[pv0]}, 32'h00221133);
    chk("rst_pre_data", {8'd0, px.pixel_data}, 32'h00554466);
    chk("rst_pre_index", {24'd0, px.pixel_index}, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_data", {8'd0, px.pixel_data}, 32'd0);
    chk("rst_mid_index", {24'd0, px.pixel_index}, 0);
    outs_all = {px.pixel_valid, px.frame_done, px.err_glitch, px.err_partial, px.err_overflow};
    chk("rst_mid_pulses", outs_all, 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    snap();
    send_pixel(8'h01, 8'h02, 8'h03);
    drive(1'b0, 100);
    chk("rst_post_valid_cnt", pv_n - pv0, 0);
    chk("rst_post_frame_done", fd_n - fd0, 0);
    chk("rst_post_errors", (gl_n - gl0) + (pa_n - pa0) + (ov_n - ov0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/neopixel_decoder.md
Name: neopixel_decoder

Overview:
- Receives a WS2812/NeoPixel single-wire bitstream and recovers 24-bit pixel words, frame boundaries and protocol errors.
- Mirror of the on-chip NeoPixel driver. Used in loopback test and for snooping external strings; its pixel output uses the same {red,green,blue} packing as the control interface read data.
- Single clock domain. The din input is asynchronous and passes through a 2-flop synchronizer.

Parameters:
C_PIXELS, 12, maximum pixels accepted per frame; excess pixels are flagged and dropped
C_BIT_THRESH_CYCLES, 75, high time >= this many cycles decodes as 1, otherwise 0 (0.6 us at 125 MHz)
C_MIN_HIGH_CYCLES, 12, high time below this is a glitch
C_MAX_HIGH_CYCLES, 250, high time reaching this ends the frame (driver idles high)
C_LATCH_CYCLES, 6250, low time reaching this is latch/reset (50 us at 125 MHz)

Ports:
neopixel_clock  in  1  block clock
neopixel_reset  in  1  asynchronous, active-low reset
neopixel_din  in  1  serial NeoPixel line, asynchronous
pixel_valid  out  1  one-cycle pulse: pixel_data/pixel_index valid
pixel_data  out  24  {red,green,blue}; wire order is G,R,B, each MSB first
pixel_index  out  8  pixel position within the frame, 0-based
frame_done  out  1  one-cycle pulse at frame end
frame_pixels  out  8  complete pixels in the frame just ended; valid with frame_done
err_glitch  out  1  one-cycle pulse: high pulse shorter than C_MIN_HIGH_CYCLES
err_partial  out  1  one-cycle pulse: frame ended with 1..23 bits pending
err_overflow  out  1  one-cycle pulse: pixel beyond C_PIXELS dropped

Behaviour:
- Reset (neopixel_reset=0, asynchronous): all outputs 0, synchronizer flops 0, counters 0, state ST_WAIT_LATCH.
- din_s = output of the 2-flop synchronizer. All decisions use din_s. hi_cnt and lo_cnt are 16-bit saturating counters; bit_cnt is 0..23.
- ST_WAIT_LATCH: lo_cnt counts cycles with din_s=0 and clears when din_s=1. lo_cnt==C_LATCH_CYCLES -> ST_IDLE. No outputs.
- ST_IDLE: din_s rises -> ST_HIGH with hi_cnt=1.
- ST_HIGH: hi_cnt increments while din_s=1.
  - Falling edge, hi_cnt < C_MIN_HIGH_CYCLES -> err_glitch; discard the partial pixel; -> ST_WAIT_LATCH.
  - Falling edge otherwise -> shift in bit (hi_cnt>=C_BIT_THRESH_CYCLES), bit_cnt+1; -> ST_LOW with lo_cnt=1.
  - hi_cnt reaches C_MAX_HIGH_CYCLES -> end-of-frame handling; -> ST_WAIT_LATCH.
- ST_LOW:
  - Rising edge -> ST_HIGH.
  - lo_cnt reaches C_LATCH_CYCLES -> end-of-frame handling; -> ST_IDLE.
- Pixel completion: the 24th bit shifts in -> next cycle pixel_valid=1, pixel_data reordered from G,R,B to {R,G,B}, pixel_index=pix_cnt, pix_cnt+1, bit_cnt=0.
  - If pix_cnt==C_PIXELS: no pixel_valid; err_overflow instead; pix_cnt holds.
  - Latency: pixel_valid rises on the 3rd clock edge after the final falling edge at neopixel_din.
- End-of-frame handling:
  - bit_cnt!=0 -> err_partial, partial bits discarded.
  - pix_cnt>0 -> frame_done=1, frame_pixels=pix_cnt.
  - Then pix_cnt=0, bit_cnt=0. Errors and frame_done may pulse in the same cycle.
- Data outputs hold their values between pulses. All pulses last exactly one cycle.
- Reset asserted mid-frame: the frame is abandoned with no frame_done. After release, input is ignored until a full latch-length low.

Test Plan:
- Hold din low for 6300 cycles, then send 1 pixel G=0x00,R=0x80,B=0xFF (1 = 100 high/55 low, 0 = 50 high/108 low), then low for 6300 cycles -> one pixel_valid, pixel_data=0x8000FF, pixel_index=0; frame_done with frame_pixels=1; no errors.
- After latch, send 12 pixels of 0xA5 bytes, then hold high -> pixel_index 0..11, each pixel_data=0xA5A5A5; frame_done with frame_pixels=12 once hi_cnt hits 250; the next frame is accepted only after 6250 cycles low.
- Threshold boundary: high pulses of exactly 74 and 75 cycles -> decoded 0 and 1 respectively; 11-cycle high mid-pixel -> err_glitch, no pixel_valid until a new latch.
- Send 10 bits, then low for 6300 cycles -> err_partial=1; frame_done only if earlier pixels completed; no pixel_valid.
- Send 13 pixels with C_PIXELS=12 -> 12 pixel_valid pulses, err_overflow once on the 13th, frame_pixels=12.
- Assert reset during pixel 3 -> outputs 0 immediately; no frame_done; a subsequent frame without a leading latch-length low is ignored.
